// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - raw push-button pins and their conditioned level/strobe outputs
interface key_debounce_if #(
    parameter int N_KEYS = 6
);
    logic [N_KEYS-1:0] btn_in;
    logic [N_KEYS-1:0] btn_level;
    logic [N_KEYS-1:0] btn_press;
    logic [N_KEYS-1:0] btn_release;
    logic [N_KEYS-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debounce FSM and press/release/auto-repeat strobes
module key_debounce #(
    parameter int N_KEYS              = 6,
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_EN           = 0,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    key_debounce_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] level_v;
    logic [N_KEYS-1:0] press_v;
    logic [N_KEYS-1:0] release_v;
    logic [N_KEYS-1:0] repeat_v;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic          meta;
        logic          sync;
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic          cnt_done;
        logic          press_nxt;
        logic          rel_nxt;
        logic          lvl_q;
        logic          press_q;
        logic          rel_q;
        logic          rep_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                meta <= 1'b0;
                sync <= 1'b0;
            end else begin
                meta <= bus.btn_in[k];
                sync <= meta;
            end
        end

        assign cnt_done = (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE: begin
                    if (sync) state_nxt = PRESS_CHK;
                end
                PRESS_CHK: begin
                    if (!sync)         state_nxt = IDLE;
                    else if (cnt_done) state_nxt = HELD;
                end
                HELD: begin
                    if (!sync) state_nxt = REL_CHK;
                end
                REL_CHK: begin
                    if (sync)          state_nxt = HELD;
                    else if (cnt_done) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_comb begin
            press_nxt = (state == PRESS_CHK) && sync && cnt_done;
            rel_nxt   = (state == REL_CHK) && !sync && cnt_done;
        end

        // cnt stops at CNT_LAST because the FSM leaves the check state on that very edge
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt     <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                case (state)
                    PRESS_CHK: cnt <= (sync && !cnt_done) ? cnt + CW'(1) : '0;
                    REL_CHK:   cnt <= (!sync && !cnt_done) ? cnt + CW'(1) : '0;
                    default:   cnt <= '0;
                endcase
                lvl_q   <= (state_nxt == HELD) || (state_nxt == REL_CHK);
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                  REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
            localparam int RW = $clog2(RMAX) + 1;
            localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
            localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

            logic [RW-1:0] rcnt;
            logic          rep_started;
            logic          rep_hit;

            assign rep_hit = (rcnt == (rep_started ? RATE_LAST : DELAY_LAST));

            // Only HELD advances the schedule; REL_CHK freezes it so a bounce merely delays repeats
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rcnt        <= '0;
                    rep_started <= 1'b0;
                    rep_q       <= 1'b0;
                end else begin
                    case (state)
                        HELD: begin
                            if (rep_hit) begin
                                rcnt        <= '0;
                                rep_started <= 1'b1;
                                rep_q       <= 1'b1;
                            end else begin
                                rcnt  <= rcnt + RW'(1);
                                rep_q <= 1'b0;
                            end
                        end
                        REL_CHK: rep_q <= 1'b0;
                        default: begin
                            rcnt        <= '0;
                            rep_started <= 1'b0;
                            rep_q       <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_norep
            assign rep_q = 1'b0;
        end

        assign level_v[k]   = lvl_q;
        assign press_v[k]   = press_q;
        assign release_v[k] = rel_q;
        assign repeat_v[k]  = rep_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_repeat  = repeat_v;
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
module tb_key_debounce;
    localparam int NK   = 6;
    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_debounce_if #(.N_KEYS(NK)) bus ();

    key_debounce #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_EN(1),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES(RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a key flips once the synchronised input has disagreed with the
    // accepted level for DEB+1 consecutive edges; repeats follow held-edge counts.
    logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
    int m_run  [NK];
    int m_held [NK];

    typedef struct {
        logic [NK-1:0] btn;
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
    } vec_t;
    vec_t tbl [40];

    task automatic chk(input string name, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int k = 0; k < NK; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [NK-1:0] b);
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int k = 0; k < NK; k++) begin
            if (m_level[k] && m_run[k] == 0) begin
                m_held[k]++;
                if (m_held[k] >= DLY && (m_held[k] - DLY) % RATE == 0) m_rep[k] = 1'b1;
            end
            if (m_s2[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB + 1) begin
                    m_level[k] = m_s2[k];
                    m_run[k]   = 0;
                    m_held[k]  = 0;
                    if (m_s2[k]) m_press[k] = 1'b1;
                    else         m_rel[k]   = 1'b1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic check_model();
        chk("model_level",   bus.btn_level,   m_level);
        chk("model_press",   bus.btn_press,   m_press);
        chk("model_release", bus.btn_release, m_rel);
        chk("model_repeat",  bus.btn_repeat,  m_rep);
    endtask

    task automatic cyc(input logic [NK-1:0] b);
        bus.btn_in = b;
        @(posedge clk);
        if (rst) model_edge(b);
        else     model_reset();
        #1;
        check_model();
    endtask

    task automatic async_reset_check();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_level",   bus.btn_level,   '0);
        chk("async_rst_press",   bus.btn_press,   '0);
        chk("async_rst_release", bus.btn_release, '0);
        chk("async_rst_repeat",  bus.btn_repeat,  '0);
        #2;
        rst = 1'b1;
    endtask

    logic [NK-1:0] cur;

    initial begin
        for (int i = 0; i < 40; i++) begin
            tbl[i].btn   = (i < 30) ? 6'h02 : 6'h00;
            tbl[i].level = (i >= 6 && i < 36) ? 6'h02 : 6'h00;
            tbl[i].press = (i == 6) ? 6'h02 : 6'h00;
            tbl[i].rel   = (i == 36) ? 6'h02 : 6'h00;
            tbl[i].rep   = (i == 16 || i == 19 || i == 22 || i == 25 || i == 28 || i == 31)
                           ? 6'h02 : 6'h00;
        end

        model_reset();
        bus.btn_in = 6'h3F;

        // All keys pressed through reset, then a single press after the full debounce
        for (int i = 0; i < 3; i++) begin
            cyc(6'h3F);
            chk("rst_level", bus.btn_level, 6'h00);
            chk("rst_press", bus.btn_press, 6'h00);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(6'h3F);
            chk("t1_press", bus.btn_press, (i == 6) ? 6'h3F : 6'h00);
            chk("t1_level", bus.btn_level, (i >= 6) ? 6'h3F : 6'h00);
        end
        for (int i = 0; i < 10; i++) cyc(6'h00);

        // Bouncy key 0 never stable long enough
        for (int i = 0; i < 14; i++) begin
            cyc(((i / 2) % 2 == 0 && i < 8) ? 6'h01 : 6'h00);
            chk("t2_level0", {5'd0, bus.btn_level[0]}, 6'h00);
            chk("t2_press0", {5'd0, bus.btn_press[0]}, 6'h00);
        end

        // Key 1 held 30 cycles: press, repeat train, release
        for (int i = 0; i < 40; i++) begin
            cyc(tbl[i].btn);
            chk("t3_level",   bus.btn_level,   tbl[i].level);
            chk("t3_press",   bus.btn_press,   tbl[i].press);
            chk("t3_release", bus.btn_release, tbl[i].rel);
            chk("t3_repeat",  bus.btn_repeat,  tbl[i].rep);
        end
        for (int i = 0; i < 4; i++) cyc(6'h00);

        // Key 2 held with a 2-cycle low bounce: repeats slip by 2
        for (int i = 0; i < 30; i++) begin
            cyc((i == 10 || i == 11) ? 6'h00 : 6'h04);
            chk("t4_release2", {5'd0, bus.btn_release[2]}, 6'h00);
            if (i >= 6) chk("t4_level2", {5'd0, bus.btn_level[2]}, 6'h01);
            chk("t4_repeat2", {5'd0, bus.btn_repeat[2]},
                (i == 18 || i == 21 || i == 24 || i == 27) ? 6'h01 : 6'h00);
        end
        for (int i = 0; i < 10; i++) cyc(6'h00);

        // Key 3 pressed while key 4 released on the same edge
        for (int i = 0; i < 8; i++) cyc(6'h10);
        for (int i = 0; i < 8; i++) begin
            cyc(6'h08);
            chk("t5_press",   bus.btn_press,   (i == 6) ? 6'h08 : 6'h00);
            chk("t5_release", bus.btn_release, (i == 6) ? 6'h10 : 6'h00);
        end
        for (int i = 0; i < 10; i++) cyc(6'h00);

        // Reset mid-PRESS_CHK, then mid-HELD
        for (int i = 0; i < 3; i++) cyc(6'h20);
        async_reset_check();
        for (int i = 0; i < 8; i++) begin
            cyc(6'h20);
            chk("t6_press", bus.btn_press, (i == 6) ? 6'h20 : 6'h00);
        end
        for (int i = 0; i < 3; i++) cyc(6'h20);
        async_reset_check();
        for (int i = 0; i < 10; i++) begin
            cyc(6'h00);
            chk("t6_no_strobe", bus.btn_press | bus.btn_release, 6'h00);
        end

        // Random keys with slow toggling
        cur = '0;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
            cyc(cur);
            chk("rand_excl", bus.btn_press & bus.btn_release, 6'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
